fb_row_writer: RTL and testbench

Downstream consumer of the pattern generator's frame-buffer write interface. Captures one row of 24-bit pixels into a ping-pong line buffer. On row store, it copies the captured row into the external frame memory at the given row address. It manages the back/front frame selection (`frame_swap`/`frame_rdy`) in sync with the display scan-out's vsync.

---
 rtl/fb_pkg.sv | 16 +
 rtl/fb_line_ram.sv | 31 +++
 rtl/fb_row_writer.sv | 145 ++++++++++++++
 tb/tb_fb_row_writer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer row writer: copy FSM encoding,
// pixel width and the {frame_sel,row,col} memory address layout.
package fb_pkg;

  localparam int FB_PIX_W = 24;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  // Frame memory address is {frame_sel, row, col}; frame_sel is the MSB.
  function automatic int fb_addr_w(input int log_rows, input int log_cols);
    return 1 + log_rows + log_cols;
  endfunction

endpackage

// File: rtl/fb_line_ram.sv
// Ping-pong line buffer: two rows of pixels, buffer select is the address MSB.
// One write port and one read port with a single-cycle registered read.
module fb_line_ram
  import fb_pkg::*;
#(
  parameter int N_COLS     = 64,
  parameter int LOG_N_COLS = $clog2(N_COLS)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [LOG_N_COLS:0]   waddr_i,
  input  logic [FB_PIX_W-1:0]   wdata_i,
  input  logic [LOG_N_COLS:0]   raddr_i,
  output logic [FB_PIX_W-1:0]   rdata_o
);

  logic [FB_PIX_W-1:0] mem_q [0:(2 << LOG_N_COLS)-1];
  logic [FB_PIX_W-1:0] rdata_q;

  // NOTE: neither the array nor the read register is reset, so this maps onto
  // block RAM; adding a reset here would force it into flops.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fb_row_writer.sv
// Captures a pixel row into a ping-pong line buffer and copies it to frame memory.
// Define FB_DOUBLE_BUF_EN for vsync-synchronised back/front frame swapping.
module fb_row_writer
  import fb_pkg::*;
#(
  parameter int N_ROWS     = 64,
  parameter int N_COLS     = 64,
  parameter int LOG_N_ROWS = $clog2(N_ROWS),
  parameter int LOG_N_COLS = $clog2(N_COLS)
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic [LOG_N_ROWS-1:0]                       fbw_row_addr,
  input  logic                                        fbw_row_store,
  output logic                                        fbw_row_rdy,
  input  logic                                        fbw_row_swap,
  input  logic [FB_PIX_W-1:0]                         fbw_data,
  input  logic [LOG_N_COLS-1:0]                       fbw_col_addr,
  input  logic                                        fbw_wren,
  input  logic                                        frame_swap,
  output logic                                        frame_rdy,
  input  logic                                        disp_vsync,
  output logic [fb_addr_w(LOG_N_ROWS, LOG_N_COLS)-1:0] mem_addr,
  output logic [FB_PIX_W-1:0]                         mem_data,
  output logic                                        mem_we,
  input  logic                                        mem_rdy
);

  localparam logic [LOG_N_COLS-1:0] LAST_COL = LOG_N_COLS'(N_COLS - 1);

  logic [1:0]            state_q, state_d;
  logic [LOG_N_COLS-1:0] col_q, col_d;
  logic [LOG_N_ROWS-1:0] row_q, row_d;
  logic                  cap_sel_q, cap_sel_d;
  logic                  copy_sel_q, copy_sel_d;
  logic [FB_PIX_W-1:0]   ram_rdata;
  logic                  back_sel;

  fb_line_ram #(
    .N_COLS     (N_COLS),
    .LOG_N_COLS (LOG_N_COLS)
  ) u_line_ram (
    .clk     (clk),
    .we_i    (fbw_wren),
    .waddr_i ({cap_sel_q, fbw_col_addr}),
    .wdata_i (fbw_data),
    .raddr_i ({copy_sel_q, col_q}),
    .rdata_o (ram_rdata)
  );

  // NOTE: every _d gets its default before the case so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    copy_sel_d = copy_sel_q;
    cap_sel_d  = cap_sel_q ^ fbw_row_swap;
    case (state_q)
      ST_IDLE: begin
        if (fbw_row_store) begin
          // Source is the buffer captured so far, even if a swap lands now.
          row_d      = fbw_row_addr;
          col_d      = '0;
          copy_sel_d = cap_sel_q;
          state_d    = ST_READ;
        end
      end
      ST_READ:  state_d = ST_WRITE;
      ST_WRITE: begin
        if (mem_rdy) begin
          if (col_q == LAST_COL) begin
            state_d = ST_IDLE;
          end else begin
            col_d   = col_q + 1'b1;
            state_d = ST_READ;
          end
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      col_q      <= '0;
      row_q      <= '0;
      cap_sel_q  <= 1'b0;
      copy_sel_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      cap_sel_q  <= cap_sel_d;
      copy_sel_q <= copy_sel_d;
    end
  end

  assign fbw_row_rdy = (state_q == ST_IDLE);
  assign mem_we      = (state_q == ST_WRITE);
  // Read address is held during a stalled write, so the RAM output stays put.
  assign mem_addr    = mem_we ? {back_sel, row_q, col_q} : '0;
  assign mem_data    = mem_we ? ram_rdata : '0;

`ifdef FB_DOUBLE_BUF_EN
  // The front frame is always ~back_sel, so only the back selection is stored.
  logic back_sel_q, pending_q, frame_rdy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      back_sel_q  <= 1'b1;
      pending_q   <= 1'b0;
      frame_rdy_q <= 1'b1;
    end else if (frame_swap) begin
      pending_q   <= 1'b1;
      frame_rdy_q <= 1'b0;
    end else if (disp_vsync && pending_q) begin
      back_sel_q  <= ~back_sel_q;
      pending_q   <= 1'b0;
      frame_rdy_q <= 1'b1;
    end
  end

  assign back_sel  = back_sel_q;
  assign frame_rdy = frame_rdy_q;
`else
  // Single buffer: frame_rdy only blinks low for one cycle after a swap.
  logic frame_rdy_q;
  logic unused_vsync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_rdy_q <= 1'b1;
    end else begin
      frame_rdy_q <= ~frame_swap;
    end
  end

  assign unused_vsync = disp_vsync;
  assign back_sel     = 1'b0;
  assign frame_rdy    = frame_rdy_q;
`endif

endmodule

// File: tb/tb_fb_row_writer.sv
// Scoreboard bench for fb_row_writer: stores push expected memory beats,
// a negedge monitor pops and compares every accepted write.
module tb_fb_row_writer;

  localparam int NR = 64;
  localparam int NC = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  fbw_row_addr;
  logic        fbw_row_store;
  logic        fbw_row_rdy;
  logic        fbw_row_swap;
  logic [23:0] fbw_data;
  logic [5:0]  fbw_col_addr;
  logic        fbw_wren;
  logic        frame_swap;
  logic        frame_rdy;
  logic        disp_vsync;
  logic [12:0] mem_addr;
  logic [23:0] mem_data;
  logic        mem_we;
  logic        mem_rdy;

  fb_row_writer #(.N_ROWS(NR), .N_COLS(NC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fbw_row_addr  (fbw_row_addr),
    .fbw_row_store (fbw_row_store),
    .fbw_row_rdy   (fbw_row_rdy),
    .fbw_row_swap  (fbw_row_swap),
    .fbw_data      (fbw_data),
    .fbw_col_addr  (fbw_col_addr),
    .fbw_wren      (fbw_wren),
    .frame_swap    (frame_swap),
    .frame_rdy     (frame_rdy),
    .disp_vsync    (disp_vsync),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .mem_we        (mem_we),
    .mem_rdy       (mem_rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [12:0] addr;
    logic [23:0] data;
  } beat_t;

  beat_t       expq[$];
  beat_t       mon_e;
  logic [23:0] mbuf [2][NC];
  int          mcap;
  bit          mback;
  bit          reset_back;
  int          checks = 0;
  int          errors = 0;
  int          beats  = 0;
  int          rdy_mode = 0;
  bit          held = 0;
  logic [12:0] h_addr;
  logic [23:0] h_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory ready pattern: always, 1-of-3, or random.
  initial begin
    int k = 0;
    mem_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      k++;
      case (rdy_mode)
        0:       mem_rdy = 1'b1;
        1:       mem_rdy = (k % 3 == 0);
        default: mem_rdy = 1'($urandom_range(1, 0));
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      held = 0;
    end else if (mem_we) begin
      if (held) begin
        check("hold_addr", 32'(mem_addr), 32'(h_addr));
        check("hold_data", 32'(mem_data), 32'(h_data));
      end
      if (mem_rdy) begin
        held = 0;
        beats++;
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: addr %0h data %0h but none expected", mem_addr, mem_data);
        end else begin
          mon_e = expq.pop_front();
          check("beat_addr", 32'(mem_addr), 32'(mon_e.addr));
          check("beat_data", 32'(mem_data), 32'(mon_e.data));
        end
      end else begin
        held   = 1;
        h_addr = mem_addr;
        h_data = mem_data;
      end
    end else begin
      held = 0;
    end
  end

  task automatic write_px(input int col, input logic [23:0] d);
    fbw_wren     = 1'b1;
    fbw_col_addr = 6'(col);
    fbw_data     = d;
    tick();
    fbw_wren     = 1'b0;
    mbuf[mcap][col] = d;
  endtask

  task automatic fill_row(input bit rnd);
    for (int c = 0; c < NC; c++)
      write_px(c, rnd ? 24'($urandom) : 24'(c * 24'h010101));
  endtask

  task automatic wait_rdy(input string name, input int budget);
    int n = 0;
    while (!fbw_row_rdy && n < budget) begin
      tick();
      n++;
    end
    if (!fbw_row_rdy) begin
      checks++;
      errors++;
      $display("FAIL %s: fbw_row_rdy still 0 after %0d cycles, required 1", name, budget);
    end
  endtask

  task automatic store_row(input int row, input bit sw);
    beat_t b;
    wait_rdy("store_wait", 2000);
    fbw_row_addr  = 6'(row);
    fbw_row_store = 1'b1;
    fbw_row_swap  = sw;
    for (int c = 0; c < NC; c++) begin
      b.addr = {mback, 6'(row), 6'(c)};
      b.data = mbuf[mcap][c];
      expq.push_back(b);
    end
    if (sw) mcap ^= 1;
    tick();
    fbw_row_store = 1'b0;
    fbw_row_swap  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    wait_rdy(name, 2000);
    check({name, "_queue_empty"}, 32'(expq.size()), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int b0, cnt, n, row;
`ifdef FB_DOUBLE_BUF_EN
    reset_back = 1'b1;
`else
    reset_back = 1'b0;
`endif
    mback = reset_back;
    mcap  = 0;
    fbw_row_addr = '0; fbw_row_store = 0; fbw_row_swap = 0;
    fbw_data = '0; fbw_col_addr = '0; fbw_wren = 0;
    frame_swap = 0; disp_vsync = 0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    repeat (3) tick();
    check("rst_row_rdy", 32'(fbw_row_rdy), 1);
    check("rst_frame_rdy", 32'(frame_rdy), 1);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_data", 32'(mem_data), 0);
    rst_n = 1'b1;
    tick();

    // Single row, mem_rdy always 1: 128 busy cycles, 64 beats.
    fill_row(0);
    b0 = beats;
    store_row(5, 1);
    check("busy_after_store", 32'(fbw_row_rdy), 0);
    cnt = 0;
    while (!fbw_row_rdy && cnt < 1000) begin
      cnt++;
      tick();
    end
    check("rdy_low_cycles", 32'(cnt), 128);
    check("t1_beats", 32'(beats - b0), 64);
    check("t1_queue_empty", 32'(expq.size()), 0);

    // Backpressure, ping-pong fill and a store while busy.
    rdy_mode = 1;
    fill_row(1);
    b0 = beats;
    store_row(5, 1);
    for (int c = 0; c < NC; c++) begin
      if (c == 30) begin
        check("busy_rdy", 32'(fbw_row_rdy), 0);
        fbw_row_store = 1'b1;
        fbw_row_addr  = 6'd9;
      end
      write_px(c, 24'($urandom));
      fbw_row_store = 1'b0;
    end
    wait_done("t2_first");
    check("t2_first_beats", 32'(beats - b0), 64);
    store_row(6, 1);
    wait_done("t2_second");
    check("t2_total_beats", 32'(beats - b0), 128);

    // Frame swap then vsync 10 cycles later.
    rdy_mode = 0;
    wait_rdy("t3_wait", 2000);
    frame_swap = 1'b1;
    tick();
    frame_swap = 1'b0;
    check("swap_frame_rdy_low", 32'(frame_rdy), 0);
`ifdef FB_DOUBLE_BUF_EN
    for (int i = 0; i < 9; i++) begin
      tick();
      check("swap_frame_rdy_hold", 32'(frame_rdy), 0);
    end
    disp_vsync = 1'b1;
    tick();
    disp_vsync = 1'b0;
    check("vsync_frame_rdy", 32'(frame_rdy), 1);
    mback ^= 1;
    // Coincident swap and vsync: swap wins, wait for the next vsync.
    frame_swap = 1'b1; disp_vsync = 1'b1;
    tick();
    frame_swap = 1'b0; disp_vsync = 1'b0;
    check("coinc_frame_rdy_low", 32'(frame_rdy), 0);
    tick();
    check("coinc_frame_rdy_hold", 32'(frame_rdy), 0);
    disp_vsync = 1'b1;
    tick();
    disp_vsync = 1'b0;
    check("coinc_frame_rdy_high", 32'(frame_rdy), 1);
    mback ^= 1;
`else
    tick();
    check("swap_frame_rdy_pulse", 32'(frame_rdy), 1);
    repeat (8) tick();
    disp_vsync = 1'b1;
    tick();
    disp_vsync = 1'b0;
    check("vsync_ignored", 32'(frame_rdy), 1);
`endif
    fill_row(1);
    store_row(int'($urandom_range(NR - 1, 0)), 1);
    wait_done("t3_row");

    // Random mem_rdy, random row.
    rdy_mode = 2;
    fill_row(1);
    store_row(int'($urandom_range(NR - 1, 0)), 1);
    wait_done("t4_row");

    // Reset in the middle of a copy, after beat 20.
    rdy_mode = 0;
    fill_row(1);
    b0 = beats;
    store_row(12, 1);
    n = 0;
    while (!((beats - b0 >= 20) && mem_we) && n < 500) begin
      tick();
      n++;
    end
    check("pre_reset_mem_we", 32'(mem_we), 1);
    rst_n = 1'b0;
    #1;
    check("reset_mem_we", 32'(mem_we), 0);
    check("reset_row_rdy", 32'(fbw_row_rdy), 1);
    check("reset_frame_rdy", 32'(frame_rdy), 1);
    check("reset_mem_addr", 32'(mem_addr), 0);
    expq.delete();
    mcap  = 0;
    mback = reset_back;
    tick();
    rst_n = 1'b1;
    tick();
    check("post_reset_mem_we", 32'(mem_we), 0);
    fill_row(1);
    row = int'($urandom_range(NR - 1, 0));
    store_row(row, 1);
    wait_done("t5_row");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
